// File: rtl/audio_pkg.sv
// audio_pkg: shared audio path constants and frame-length helper.
package audio_pkg;
   localparam int SAMPLE_BITS = 24;
   localparam int SLOT_BITS   = 32;
   localparam int SLOTS       = 2;
   function automatic int frame_len(input int bck_half);
      return SLOT_BITS * SLOTS * 2 * bck_half;
   endfunction
   localparam int FRAME_LEN = frame_len(4);
   localparam int CNT_BITS  = $clog2(FRAME_LEN);
endpackage

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: stereo I2S transmitter; frame counter with registered decode of every output.
module audio_i2s_tx
   import audio_pkg::*;
#(
   parameter int BCK_HALF = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic signed [SAMPLE_BITS-1:0] left_in,
   input  logic signed [SAMPLE_BITS-1:0] right_in,
   output logic                       next_sample,
   output logic                       i2s_bck,
   output logic                       i2s_lrck,
   output logic                       i2s_data
);
   localparam int P2 = 2 * BCK_HALF;
   localparam int F  = frame_len(BCK_HALF);
   localparam int W  = $clog2(F);
   logic [W-1:0] p;
   logic [SAMPLE_BITS-1:0] hold_l, hold_r;
   logic [5:0] b;
   logic [4:0] s, idx;
   logic bck_d, lrck_d, data_d;
   always_comb begin
      b      = 6'(p / W'(P2));
      s      = b[4:0];
      idx    = 5'(SAMPLE_BITS) - s;
      bck_d  = (p % W'(P2)) >= W'(BCK_HALF);
      lrck_d = b[5];
      // s = 0 is the I2S one-bit delay; s above the sample width is padding
      data_d = (s >= 5'd1 && s <= 5'(SAMPLE_BITS)) ? (lrck_d ? hold_r[idx] : hold_l[idx]) : 1'b0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         p           <= '0;
         hold_l      <= '0;
         hold_r      <= '0;
         next_sample <= 1'b0;
         i2s_bck     <= 1'b0;
         i2s_lrck    <= 1'b0;
         i2s_data    <= 1'b0;
      end else begin
         p           <= (p == W'(F - 1)) ? '0 : p + W'(1);
         next_sample <= (p == '0);
         i2s_bck     <= bck_d;
         i2s_lrck    <= lrck_d;
         i2s_data    <= data_d;
         if (p == '0) begin
            hold_l <= left_in;
            hold_r <= right_in;
         end
      end
   end
endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: directed plus random stimulus against a frame-level model, default and BCK_HALF=2 instances.
module tb_audio_i2s_tx;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic signed [23:0] left_in = '0, right_in = '0;
   logic ns_a, bck_a, lrck_a, data_a;
   logic ns_b, bck_b, lrck_b, data_b;
   int total = 0, bad = 0;

   audio_i2s_tx dut_a (.clk(clk), .rst(rst), .left_in(left_in), .right_in(right_in),
      .next_sample(ns_a), .i2s_bck(bck_a), .i2s_lrck(lrck_a), .i2s_data(data_a));
   audio_i2s_tx #(.BCK_HALF(2)) dut_b (.clk(clk), .rst(rst), .left_in(left_in), .right_in(right_in),
      .next_sample(ns_b), .i2s_bck(bck_b), .i2s_lrck(lrck_b), .i2s_data(data_b));

   always #5 clk = ~clk;

   int pa = 0, pb = 0;
   logic [23:0] hl_a = '0, hr_a = '0, hl_b = '0, hr_b = '0;
   logic [31:0] cap_a = '0;
   logic prev_bck_a = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         if (bad <= 30) $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected bit at a frame position, straight from the slot layout: delay bit, 24 MSB-first bits, padding.
   function automatic logic exp_data(input int pos, input int half, input logic [23:0] l, input logic [23:0] r);
      int bi, s;
      logic [23:0] w;
      bi = pos / (2 * half);
      s  = bi % 32;
      w  = (bi < 32) ? l : r;
      return (s >= 1 && s <= 24) ? w[24 - s] : 1'b0;
   endfunction

   task automatic check_pos(input string tag, input int pos, input int half, input logic [23:0] l,
                            input logic [23:0] r, input logic ns, input logic bck, input logic lrck, input logic d);
      chk({tag, "_ns"}, 32'(ns), 32'(pos == 0));
      chk({tag, "_bck"}, 32'(bck), 32'((pos % (2 * half)) >= half));
      chk({tag, "_lrck"}, 32'(lrck), 32'(pos >= 64 * half));
      chk({tag, "_data"}, 32'(d), 32'(exp_data(pos, half, l, r)));
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         if (rst) begin
            pa = 0; pb = 0;
            hl_a = '0; hr_a = '0; hl_b = '0; hr_b = '0;
            #1;
            chk("rst_a", {28'd0, ns_a, bck_a, lrck_a, data_a}, 32'd0);
            chk("rst_b", {28'd0, ns_b, bck_b, lrck_b, data_b}, 32'd0);
            cap_a = '0;
            prev_bck_a = 1'b0;
         end else begin
            if (pa == 0) begin hl_a = left_in; hr_a = right_in; end
            if (pb == 0) begin hl_b = left_in; hr_b = right_in; end
            #1;
            check_pos("a", pa, 4, hl_a, hr_a, ns_a, bck_a, lrck_a, data_a);
            check_pos("b", pb, 2, hl_b, hr_b, ns_b, bck_b, lrck_b, data_b);
            // receiver view: shift in on each BCK rising edge, compare whole slots
            if (bck_a && !prev_bck_a) cap_a = {cap_a[30:0], data_a};
            prev_bck_a = bck_a;
            if (pa == 255) chk("slot_left", cap_a, {1'b0, hl_a, 7'd0});
            if (pa == 511) chk("slot_right", cap_a, {1'b0, hr_a, 7'd0});
            pa = (pa + 1) % 512;
            pb = (pb + 1) % 256;
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      @(posedge clk); #1;
      step(5);
      left_in  = 24'sh800001;
      right_in = 24'sh7FFFFE;
      rst = 1'b0;
      step(1024);
      step(100);
      left_in = 24'sh123456;
      step(412 + 512);
      chk("left_latched", 32'(hl_a), 32'h123456);
      step(300);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(600);
      for (int k = 0; k < 6; k++) begin
         left_in  = 24'($urandom);
         right_in = 24'($urandom);
         step(int'($urandom_range(50, 700)));
      end
      step(512);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Stereo I2S transmitter at the output of the audio path. Generates the 48.828 kHz `next_sample` frame strobe that paces the PCM and PSG stages. Latches the mixed left/right sample once per frame and serializes it to an external I2S DAC as 24-bit MSB-first data in 32-bit slots. With `clk` = 25 MHz the frame is 512 clk cycles.

## Interface
Parameters:
- `BCK_HALF`, default 4: clk cycles per BCK half-period. The BCK period is 2·`BCK_HALF` clk.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `left_in`  in  24 signed  mixed left sample, two's complement.
- `right_in`  in  24 signed  mixed right sample, two's complement.
- `next_sample`  out  1  one-clk pulse at each frame start. Feeds the upstream sample-rate accumulators.
- `i2s_bck`  out  1  bit clock.
- `i2s_lrck`  out  1  word select: 0 = left slot, 1 = right slot.
- `i2s_data`  out  1  serial data.

## Operation
- **Frame counter `p`.**
  - Free-running, 0 .. F−1, where F = 64·2·`BCK_HALF` (512 at default).
  - Increments every clk and wraps F−1 → 0.
  - No other state machine; every output is a registered decode of `p`.
- **Decodes for position `p`:**
  - bit index `b` = p / (2·`BCK_HALF`), range 0..63.
  - slot position `s` = b mod 32.
  - `i2s_bck` = 1 when (p mod 2·`BCK_HALF`) ≥ `BCK_HALF`, else 0.
  - `i2s_lrck` = (b ≥ 32).
  - `next_sample` = (p == 0).
  - `i2s_data`:
    - for 1 ≤ s ≤ 24: bit (24−s) of `hold_l` when b < 32, of `hold_r` when b ≥ 32.
    - otherwise 0. This covers s = 0, which is the I2S one-bit delay, and padding s = 25..31.
- **Sample latch.**
  - `hold_l` ← `left_in` and `hold_r` ← `right_in`, on the same edge that drives `next_sample` high.
  - Inputs are ignored at all other times.
  - Upstream responds to `next_sample` with multi-cycle latency, so the latched value is the result of the previous frame's strobe. This is one frame of pipeline delay, by design.
- **Edge placement.**
  - Data and LRCK change only on BCK falling edges.
  - The receiver samples on BCK rising edges, `BCK_HALF` clk after each change.
- **Width rule.**
  - Inputs are used as-is, with no saturation or rescaling.
  - The upstream mixer sign-extends the 23-bit PCM output and clamps its sum to 24 bits.

## Timing
- **Reset values.** While `rst` is high:
  - `p` = 0, `hold_l` = `hold_r` = 0.
  - `next_sample` = 0, `i2s_bck` = 0, `i2s_lrck` = 0, `i2s_data` = 0.
- **First cycles after reset.**
  - Outputs show the decode of `p` = 0 in the first cycle after the first rising edge with `rst` low. `next_sample` is high in that cycle, and `hold_*` are loaded on that edge.
  - Each following cycle advances the displayed position by one.
- **Output lag.** All outputs are registered with fixed 1-clk latency from `p`. There are no combinational paths from inputs to outputs.
- **`next_sample` period.** Exactly F clk; high for exactly 1 clk.
- **Latch-to-output.** The MSB of a latched sample appears at `p` = 2·`BCK_HALF` (left) and `p` = 33·2·`BCK_HALF` (right).
- **Boundary conditions.**
  - *Reset mid-frame:* all outputs return to reset values on the next edge. The partial frame is discarded, and the frame restarts at `p` = 0 after release.
  - *Input changes mid-frame:* no effect until the next `p` = 0.
  - *Wrap:* position F−1 is followed directly by 0, with no idle cycle.
  - *Data ownership across frames:* `s` = 0 of the left slot always carries 0, never the previous right sample's LSB, because of the padding.

## Structure
- Shared package `audio_pkg` holds:
  - `SAMPLE_BITS` = 24, `SLOT_BITS` = 32, `SLOTS` = 2.
  - derived frame length F and counter width `$clog2(F)`.
- No sub-module. Implement as a single counter plus registered decode and two holding registers.

## Test plan
- **Reset and first frame:** hold `rst` 5 cycles, release → all outputs 0 during reset; `next_sample` = 1 in the first cycle after release and then every 512 cycles; 1-cycle pulse width.
- **BCK/LRCK shape:** free run 2 frames → `i2s_bck` period 8 clk, 50% duty; `i2s_lrck` = 0 for 256 clk, then 1 for 256 clk, with transitions aligned to BCK falling edges.
- **Serial data:** `left_in` = 0x800001, `right_in` = 0x7FFFFE at the latch edge → capture on BCK rising edges.
  - left slot = 0, 1, 0×22, 1, 0×7.
  - right slot = 0, 0, 1×22, 0, 0×7.
- **Mid-frame input change:** change `left_in` to 0x123456 at `p` = 100 → current frame unchanged; next frame's left slot carries 0x123456.
- **Reset mid-frame:** assert `rst` at `p` = 300 for 1 cycle → outputs 0 in the following cycle; after release the next `next_sample` comes at the first cycle after release, with the full frame pattern intact.
- **Parameter sweep:** `BCK_HALF` = 2 → frame 256 clk, BCK period 4 clk, same bit pattern as the serial-data test.
